// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, waits a
// fixed latency, performs the byte-enabled access and returns a held response.
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cap_we;
  logic             cap_err;
  logic [IDX_W-1:0] cap_idx;
  logic [3:0]       cap_be;
  logic [31:0]      cap_wdata;
  logic             do_access;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign do_access = (state == WAIT) && (cnt == '0);

  // The error decision uses the full 32-bit address at acceptance time, so
  // high address bits can never alias into the stored word index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_err   <= (req_addr >= ADDR_LIMIT) || (req_we && (req_be == 4'b0000));
            cap_idx   <= req_addr[IDX_W+1:2];
            cap_be    <= req_be;
            cap_wdata <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= cap_err;
            resp_rdata <= (!cap_err && !cap_we) ? mem[cap_idx] : 32'd0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (do_access && cap_we && !cap_err) begin
      for (int b = 0; b < 4; b++) begin
        if (cap_be[b]) begin
          mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed requests push expected responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_dm_responder;

  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  int n_vec;
  int n_bad;
  int cyc;
  int rise_cyc;
  int last_accept;
  int resp_count;
  int accept_count;
  logic prev_valid;

  dm_responder #(.DEPTH_WORDS(3072), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Handshakes are decided by the levels visible here, half a cycle before the edge.
  initial begin
    prev_valid   = 1'b0;
    resp_count   = 0;
    accept_count = 0;
    rise_cyc     = 0;
  end

  always @(negedge clk) begin
    if (resp_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = resp_valid;
    if (req_valid && req_ready && !reset) accept_count++;
    if (resp_valid && resp_ready && !reset) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("[TB] FAIL unexpected_resp: got rdata 0x%08h err %0b, expected no response", resp_rdata, resp_err);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("resp_rdata", resp_rdata, mon_e.rdata);
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
      end
      resp_count++;
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input bit push_exp, input bit wait_resp);
    int n;
    int start;
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    if (push_exp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      expq.push_back(e);
    end
    start = resp_count;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_bad++;
      $display("[TB] FAIL accept_timeout: got req_ready 0, expected 1 within 50 cycles");
    end
    last_accept = cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_be    = 4'($urandom);
    req_wdata = $urandom;
    if (wait_resp) begin
      n = 0;
      while (resp_count == start && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (resp_count == start) begin
        n_vec++;
        n_bad++;
        $display("[TB] FAIL resp_timeout: got no response, expected one within 50 cycles");
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int c0;
    int a0;
    int n;
    int acc [4];
    logic        bw_we    [4];
    logic [3:0]  bw_be    [4];
    logic [31:0] bw_wdata [4];
    logic [31:0] bw_rdata [4];
    exp_t e;

    n_vec      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_be     = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_resp_err", {31'd0, resp_err}, 32'd0);

    applyStimulus(1'b0, 32'h0000_0010, 4'hF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("load_latency", 32'(rise_cyc - last_accept), 32'(LATENCY));

    applyStimulus(1'b1, 32'h0000_0100, 4'b1111, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0000_0100, 4'b0000, 32'd0, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0100, 4'b0101, 32'hAABB_CCDD, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0000_0100, 4'b0000, 32'd0, 32'h12BB_56DD, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0000_2FFC, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0100, 4'b0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h8000_0100, 4'b1111, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h8000_0100, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0000_0100, 4'b0000, 32'd0, 32'h12BB_56DD, 1'b0, 1'b1, 1'b1);

    // Backpressure: response must hold for five stalled cycles.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 32'h0000_0100, 4'b0000, 32'd0, 32'h12BB_56DD, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bp_resp_rdata", resp_rdata, 32'h12BB_56DD);
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    c0 = resp_count;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_after_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("bp_after_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_handshakes", 32'(resp_count - c0), 32'd1);

    // Reset one cycle after acceptance drops the pending store.
    c0 = resp_count;
    applyStimulus(1'b1, 32'h0000_0040, 4'b1111, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rst_no_resp_count", 32'(resp_count - c0), 32'd0);
    checkOutput("rst_no_resp_valid", {31'd0, resp_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0000_0040, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);

    // Back-to-back: req_valid held high across four requests.
    bw_we[0] = 1'b1; bw_be[0] = 4'b1111; bw_wdata[0] = 32'h1111_1111; bw_rdata[0] = 32'd0;
    bw_we[1] = 1'b0; bw_be[1] = 4'b0000; bw_wdata[1] = 32'd0;         bw_rdata[1] = 32'h1111_1111;
    bw_we[2] = 1'b1; bw_be[2] = 4'b0010; bw_wdata[2] = 32'h0000_AB00; bw_rdata[2] = 32'd0;
    bw_we[3] = 1'b0; bw_be[3] = 4'b0000; bw_wdata[3] = 32'd0;         bw_rdata[3] = 32'h1111_AB11;
    a0 = accept_count;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_we    = bw_we[k];
      req_addr  = 32'h0000_0200;
      req_be    = bw_be[k];
      req_wdata = bw_wdata[k];
      e.rdata   = bw_rdata[k];
      e.err     = 1'b0;
      expq.push_back(e);
      n = 0;
      while (!req_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      acc[k] = cyc + 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("b2b_accepts", 32'(accept_count - a0), 32'd4);
    for (int k = 1; k < 4; k++) begin
      checkOutput("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'(LATENCY + 2));
    end
    checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder: the memory-side end of the load/store request interface issued by the CPU datapath. It accepts one request at a time through a valid/ready handshake and waits a fixed, parameterised latency. It then performs a byte-enabled write or a full-word read and returns a response through a second valid/ready handshake. It replaces the zero-latency data memory so that stall logic in the datapath can be exercised.

## Interface
- DEPTH_WORDS, 3072, number of 32-bit words stored; legal byte addresses are 0 to DEPTH_WORDS*4-1
- LATENCY, 2, cycles from request acceptance to response; must be ≥1

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address; bits [1:0] are ignored for indexing
- req_be  input  4  byte enables for stores, bit i covers bits [8i+7:8i]; ignored for loads
- req_wdata  input  32  store data, already lane-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  requester takes the response
- resp_rdata  output  32  load data as a full word; 0 for stores and errors
- resp_err  output  1  request was out of range, or was a store with req_be==0

## Operation
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE) and is purely combinational from the state.
- IDLE: when req_valid && req_ready, capture we, word index (req_addr[31:2]), be and wdata. Set cnt = LATENCY-1 and go to WAIT.
- WAIT with cnt != 0: decrement cnt.
- WAIT with cnt == 0: perform the access and go to RESP. Access rules:
  - Error when req_addr ≥ DEPTH_WORDS*4, or when we=1 with be=4'b0000. On error: no memory change, resp_rdata=0, resp_err=1.
  - Store: write only the enabled byte lanes of mem[index]; other lanes are kept. resp_rdata=0, resp_err=0.
  - Load: resp_rdata = mem[index], resp_err=0.
- RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_valid && resp_ready, then go to IDLE.
- Leaving RESP clears resp_valid, resp_rdata and resp_err to 0 on the same edge.
- Request inputs are sampled only at the accepting edge. Changes to them afterwards have no effect.
- Only one request is ever outstanding, so read-after-write is always coherent.

## Timing
- Reset (synchronous, checked on the clock edge) does the following:
  - state←IDLE, cnt←0, resp_valid←0, resp_rdata←0, resp_err←0.
  - Every memory word is cleared to 0.
  - req_ready is therefore 1 in the first cycle after reset deasserts.
- If a request is accepted at edge T:
  - The memory update for a store occurs at edge T+LATENCY.
  - resp_valid is first seen high in the cycle after edge T+LATENCY.
- With resp_ready held high, resp_valid lasts exactly 1 cycle. The next request can be accepted at the edge after resp_valid falls.
- Minimum request-to-request spacing is LATENCY+2 cycles.
- A request presented while the block is in WAIT or RESP sees req_ready=0 and must be held by the requester.
- Reset mid-operation, in WAIT or RESP, drops the pending request: no write is performed and no response is produced.
- resp_ready is ignored outside RESP.
- A held req_valid with req_ready=0 is not an error.
- Memory index width: ceil(log2(DEPTH_WORDS)) bits of req_addr[31:2]. The range check uses the full 32-bit address, so high address bits never alias.

## Test plan
- **Load after reset:** reset for 2 cycles, then load from addr 0x0000_0010.
  - Response must be resp_rdata=0, resp_err=0.
  - resp_valid must rise in the cycle after the edge LATENCY=2 edges after acceptance.
- **Store then read back:** store 0x1234_5678 with be=1111 to 0x0000_0100, then load 0x0000_0100 → 0x1234_5678.
  - Then store 0xAABB_CCDD with be=0101 and load again → 0x12BB_56DD.
- **Range and enable errors:**
  - Store to 0x0000_3000 (DEPTH_WORDS*4) → resp_err=1, and no word changes; check via a readback of 0x0000_2FFC.
  - Store with be=0000 → resp_err=1.
  - Load from 0x0000_2FFC → resp_err=0.
- **Response backpressure:** hold resp_ready=0 for 5 cycles after resp_valid rises.
  - resp_valid and resp_rdata must stay stable and req_ready must stay 0.
  - Raise resp_ready → exactly one handshake occurs, then req_ready=1.
- **Reset mid-WAIT:** issue a store of 0xFFFF_FFFF to 0x0000_0040, then assert reset one cycle after acceptance.
  - There must be no resp_valid.
  - A later load of 0x0000_0040 → 0.
- **Back-to-back requests:** keep req_valid high with 4 queued requests and resp_ready=1.
  - Each request must be accepted exactly once.
  - Accepts must be spaced LATENCY+2 cycles apart.
